// File: rtl/vga_video_gen_pkg.sv
// Purpose: shared mode encoding, colour-bar table, control pipeline word and default 1080p60 timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  typedef enum logic [1:0] {
    GRAY   = 2'd0,
    RGB444 = 2'd1,
    BARS   = 2'd2,
    BLACK  = 2'd3
  } mode_e;

  // Bar order, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [11:0] BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Per-pixel control word carried alongside the framebuffer read
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    mode_e       mode;
    logic [11:0] bar;
  } ctl_t;

  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;
  localparam int DEF_RD_LAT   = 2;
  localparam int DEF_ADDR_W   = 21;

endpackage

// File: rtl/vga_video_gen_sync_counter.sv
// Purpose: h/v raster counters with raw (active-high) syncs, active flag and frame/line boundary decodes.
// Latency: decodes are combinational from the counter registers; active_nxt looks one cycle ahead.
// Backpressure: none, free-running on the pixel clock.
module vga_sync_counter #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic clk,
  input  logic reset,
  output logic active,
  output logic active_nxt,
  output logic hs_raw,
  output logic vs_raw,
  output logic first,
  output logic line_end,
  output logic frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;

  assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));
  assign first     = (h_cnt == '0) && (v_cnt == '0);

  // v_cnt only moves at the end of a line, so vs_raw is line-granular by construction
  assign active     = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
  assign active_nxt = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);
  assign hs_raw     = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw     = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

  // Next raster position: both counters wrap together on the last pixel of the frame
  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (line_end) begin
      h_nxt = '0;
      v_nxt = frame_end ? '0 : v_cnt + 1'b1;
    end
  end

  // Raster counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

endmodule

// File: rtl/vga_video_gen.sv
// Purpose: video timing + framebuffer fetch; converts returned pixels to RGB444 aligned with syncs/de.
// Latency: rd_en/rd_addr at 0 cycles from the raster position, video outputs at RD_LAT+1 cycles.
// Backpressure: none; the framebuffer must return rd_data exactly RD_LAT cycles after rd_en.
module vga_video_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   RD_LAT   = DEF_RD_LAT,
  parameter int   ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  // Remainder pixels of a non-multiple-of-8 width fall into the last bar
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic  active, active_nxt, hs_raw, vs_raw, first, line_end, frame_end;
  mode_e mode_q, mode_nxt;
  logic [2:0]     bar_idx;
  logic [BCW-1:0] bar_rem;
  ctl_t  ctl_in, ctl_d;
  logic [11:0] pix;

  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk(clk), .reset(reset),
    .active(active), .active_nxt(active_nxt),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .first(first),
    .line_end(line_end), .frame_end(frame_end)
  );

  // The mode present in the last cycle of a frame governs the whole next frame
  assign mode_nxt = frame_end ? mode_e'(mode) : mode_q;

  // Active-mode register: black from reset until the first frame boundary
  always_ff @(posedge clk) begin
    if (reset) mode_q <= BLACK;
    else       mode_q <= mode_nxt;
  end

  // Read strobe and running pixel address, both describing the current raster position
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= active_nxt && (mode_nxt == GRAY || mode_nxt == RGB444);
      if (frame_end)   rd_addr <= '0;
      else if (active) rd_addr <= rd_addr + 1'b1;
    end
  end

  // Bar index tracker: down-counts pixels left in the current bar, stops at the last bar
  always_ff @(posedge clk) begin
    if (reset || line_end) begin
      bar_idx <= '0;
      bar_rem <= BCW'(BAR_W - 1);
    end else if (active) begin
      if (bar_rem == '0) begin
        if (bar_idx != 3'd7) begin
          bar_idx <= bar_idx + 1'b1;
          bar_rem <= BCW'(BAR_W - 1);
        end
      end else begin
        bar_rem <= bar_rem - 1'b1;
      end
    end
  end

  // Control word for the pixel being fetched this cycle
  always_comb begin
    ctl_in      = '0;
    ctl_in.hs   = hs_raw;
    ctl_in.vs   = vs_raw;
    ctl_in.de   = active;
    ctl_in.fs   = first;
    ctl_in.mode = mode_q;
    ctl_in.bar  = BAR_COLOURS[bar_idx];
  end

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign ctl_d = ctl_in;
    end else begin : g_lat
      ctl_t pipe [RD_LAT];
      // Delay the control word so it meets the returning read data
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= ctl_in;
          for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign ctl_d = pipe[RD_LAT-1];
    end
  endgenerate

  // Pixel conversion; blanking always produces black
  always_comb begin
    pix = 12'h000;
    if (ctl_d.de) begin
      case (ctl_d.mode)
        GRAY:    pix = {3{rd_data[7:4]}};
        RGB444:  pix = rd_data;
        BARS:    pix = ctl_d.bar;
        default: pix = 12'h000;
      endcase
    end
  end

  // Output register: every video output leaves on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      {red, green, blue} <= 12'h000;
      hsync              <= ~H_POL;
      vsync              <= ~V_POL;
      de                 <= 1'b0;
      frame_start        <= 1'b0;
    end else begin
      {red, green, blue} <= pix;
      hsync              <= ctl_d.hs ? H_POL : ~H_POL;
      vsync              <= ctl_d.vs ? V_POL : ~V_POL;
      de                 <= ctl_d.de;
      frame_start        <= ctl_d.fs;
    end
  end

endmodule

// File: tb/tb_vga_video_gen.sv
// Bench for vga_video_gen: small raster (16x8 total, 8x4 visible) on two instances.
// Instance a: active-high syncs, RD_LAT 2; instance b: active-low syncs, RD_LAT 0.
// Stimulus is one linear directed sequence; expectations come from the raster position.
module tb_vga_video_gen;

  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, reset_b;
  logic [1:0]    mode_a, mode_b;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [11:0]   rd_data_a, rd_data_b;
  logic [3:0]    red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic          hsync_a, vsync_a, de_a, fs_a;
  logic          hsync_b, vsync_b, de_b, fs_b;

  // Framebuffer models: a returns data two cycles after the address, b in the same cycle
  logic [AW-1:0] m1, m2;
  logic          mem_pat;
  always @(posedge clk) begin
    m1 <= rd_addr_a;
    m2 <= m1;
  end
  assign rd_data_a = mem_pat ? 12'hA5C : {6'd0, m2};
  assign rd_data_b = {6'd0, rd_addr_b};

  vga_video_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .RD_LAT(2), .ADDR_W(AW)
  ) dut_a (
    .clk(clk), .reset(reset_a), .mode(mode_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .red(red_a), .green(green_a), .blue(blue_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(fs_a)
  );

  vga_video_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .RD_LAT(0), .ADDR_W(AW)
  ) dut_b (
    .clk(clk), .reset(reset_b), .mode(mode_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .red(red_b), .green(green_b), .blue(blue_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(fs_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int ja, jb;
  int last_fs_b = -1;
  int fm_a [8];
  logic [11:0] bars_c [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic int exp_addr(input int h, input int v);
    if (v >= 4) return 32;
    return v * 8 + ((h < 8) ? h : 8);
  endfunction

  function automatic logic [11:0] exp_pix(input int h, input int v, input int md);
    logic [3:0] g;
    if (!(h < 8 && v < 4)) return 12'h000;
    g = 4'(exp_addr(h, v) >> 4);
    case (md)
      0:       return {g, g, g};
      1:       return 12'hA5C;
      2:       return bars_c[h];
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_a();
    int h, v, jo, md;
    h  = ja % 16;
    v  = (ja / 16) % 8;
    md = fm_a[ja / 128];
    chk("a.rd_en", rd_en_a, (h < 8 && v < 4 && md < 2));
    chk("a.rd_addr", rd_addr_a, exp_addr(h, v));
    jo = ja - 3;
    if (jo < 0) begin
      chk("a.de_idle", de_a, 0);
      chk("a.fs_idle", fs_a, 0);
      chk("a.hsync_idle", hsync_a, 0);
      chk("a.vsync_idle", vsync_a, 0);
      chk("a.rgb_idle", {red_a, green_a, blue_a}, 0);
    end else begin
      h  = jo % 16;
      v  = (jo / 16) % 8;
      md = fm_a[jo / 128];
      chk("a.de", de_a, (h < 8 && v < 4));
      chk("a.fs", fs_a, (h == 0 && v == 0));
      chk("a.hsync", hsync_a, (h >= 10 && h < 13));
      chk("a.vsync", vsync_a, (v >= 5 && v < 7));
      chk("a.rgb", {red_a, green_a, blue_a}, exp_pix(h, v, md));
    end
  endtask

  task automatic check_b();
    int h, v, jo, md;
    h  = jb % 16;
    v  = (jb / 16) % 8;
    md = (jb < 128) ? 3 : 0;
    chk("b.rd_en", rd_en_b, (h < 8 && v < 4 && md < 2));
    chk("b.rd_addr", rd_addr_b, exp_addr(h, v));
    jo = jb - 1;
    if (jo < 0) begin
      chk("b.de_idle", de_b, 0);
      chk("b.hsync_idle", hsync_b, 1);
      chk("b.vsync_idle", vsync_b, 1);
    end else begin
      h  = jo % 16;
      v  = (jo / 16) % 8;
      md = (jo < 128) ? 3 : 0;
      chk("b.de", de_b, (h < 8 && v < 4));
      chk("b.fs", fs_b, (h == 0 && v == 0));
      chk("b.hsync", hsync_b, !(h >= 10 && h < 13));
      chk("b.vsync", vsync_b, !(v >= 5 && v < 7));
      chk("b.rgb", {red_b, green_b, blue_b}, exp_pix(h, v, md));
    end
    if (fs_b) begin
      if (last_fs_b >= 0) chk("b.fs_period", jb - last_fs_b, 128);
      last_fs_b = jb;
    end
  endtask

  initial begin
    bit run_b;
    run_b   = 1'b0;
    bars_c  = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    // Frame modes after the first release: black, gray, gray, bars, rgb, black, rgb
    fm_a    = '{3, 0, 0, 2, 1, 3, 1, 1};
    reset_a = 1'b1;
    reset_b = 1'b1;
    mode_a  = 2'd0;
    mode_b  = 2'd0;
    mem_pat = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    chk("rst.a.rd_en", rd_en_a, 0);
    chk("rst.a.rd_addr", rd_addr_a, 0);
    chk("rst.a.rgb", {red_a, green_a, blue_a}, 0);
    chk("rst.a.de", de_a, 0);
    chk("rst.a.fs", fs_a, 0);
    chk("rst.a.hsync", hsync_a, 0);
    chk("rst.a.vsync", vsync_a, 0);
    chk("rst.b.hsync", hsync_b, 1);
    chk("rst.b.vsync", vsync_b, 1);
    chk("rst.b.fs", fs_b, 0);

    reset_a = 1'b0;
    reset_b = 1'b0;
    ja = 0;
    jb = 0;
    for (int c = 0; c < 1075; c++) begin
      check_a();
      check_b();
      if (!run_b) begin
        if (ja == 276) mode_a = 2'd2;                       // mid-frame 2 switch to bars
        if (ja == 474) begin mode_a = 2'd1; mem_pat = 1'b1; end
        if (ja == 639) mode_a = 2'd3;                       // last cycle of frame 4 only
        if (ja == 640) mode_a = 2'd1;
        if (ja == 804) begin reset_a = 1'b1; mode_a = 2'd2; end
      end
      @(negedge clk);
      jb++;
      if (reset_a) begin
        reset_a = 1'b0;
        run_b   = 1'b1;
        ja      = 0;
        fm_a    = '{3, 2, 2, 2, 2, 2, 2, 2};
      end else begin
        ja++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_video_gen.md
# vga_video_gen

Parametrised VGA/HDMI-style video timing and pixel-fetch engine. It generates horizontal/vertical counters, programmable-polarity syncs and data-enable, and issues framebuffer read addresses. Fetched pixels are returned after a fixed read latency, converted to 4-bit-per-channel RGB and driven out cycle-aligned with the syncs. It sits between the framebuffer memory (read port) and the display PHY, and replaces the fixed 1080p pattern-only controller.

## Interface
- H_ACTIVE, 1920, visible pixels per line
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 1080, visible lines per frame
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical front porch / sync / back porch in lines
- H_POL / V_POL, 1 / 1, sync active level (1 = active-high)
- RD_LAT, 2, framebuffer read latency in cycles (legal range 0..8)
- ADDR_W, 21, framebuffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- mode  in  2  0 = grayscale, 1 = RGB444, 2 = colour bars, 3 = black
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  ADDR_W  linear pixel address
- rd_data  in  12  pixel word, valid RD_LAT cycles after rd_en
- red / green / blue  out  4 each  pixel colour
- hsync / vsync  out  1 each  syncs at H_POL / V_POL
- de  out  1  data enable (visible pixel)
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the outputs

## Operation
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H params. It wraps to 0 and then advances v_cnt, which runs 0..V_TOTAL-1 and wraps to 0.
- Region order is active, FP, sync, BP. Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Raw hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. Raw vsync uses the same rule on v_cnt and is line-granular: it changes only at h_cnt == 0.
- rd_en = active.
- rd_addr is a running linear counter: it increments on each active pixel and clears at (0,0). No multiplier.
- rd_en is forced low in mode 2 and mode 3. rd_addr still tracks.
- Mode is sampled into the active-mode register only at h_cnt == 0 and v_cnt == 0, so a frame never mixes modes.
- Pixel conversion (applied only when the delayed de is 1; otherwise RGB = 0):
  - Grayscale: red = green = blue = rd_data[7:4].
  - RGB444: {red, green, blue} = rd_data[11:0].
  - Colour bars: 8 equal bars of width H_ACTIVE/8 (integer division; remainder pixels take the last bar). Order: white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0, blue 0/0/F, black. The bar index comes from a bar-width down-counter, not a divider.
  - Mode 3: all channels 0.
- Control pipeline: hsync, vsync, de and frame_start pass through an RD_LAT+1 deep shift pipeline. The bar colour and active mode pass through the same pipeline, so every output refers to the same pixel.
- Reset:
  - Counters, rd_addr and pipeline are cleared.
  - Outputs: rd_en = 0, rd_addr = 0, RGB = 0, de = 0, frame_start = 0, hsync = ~H_POL, vsync = ~V_POL.
  - Active mode = 3 (black) until the first frame start after reset.
- Reset asserted mid-frame aborts the frame. The first cycle after release is counter (0,0); no partial-frame residue appears on the outputs.

## Timing
- Output latency is RD_LAT+1 cycles from counter state to red/green/blue/hsync/vsync/de/frame_start. All outputs are registered.
- rd_en/rd_addr are registered from the counters at latency 0, i.e. they are presented in the same cycle as the counter value they belong to.
- frame_start is high for exactly one cycle per frame: the cycle de first rises in that frame.
- de is high for exactly H_ACTIVE consecutive cycles per active line, and V_ACTIVE lines per frame.
- h_cnt/v_cnt wrap is simultaneous on the last pixel of the last line; the next cycle is (0,0).
- A mode change in the last cycle of a frame takes effect at the next (0,0).

## Structure
- Shared package vga_pkg holds:
  - the mode enum (GRAY, RGB444, BARS, BLACK),
  - the 8-entry colour-bar constant array,
  - the default 1080p timing constants.
- Sub-module vga_sync_counter holds the h/v counters, raw syncs, active flag and frame-start detect, parametrised by the timing params. vga_video_gen adds the address counter, pipeline and colour conversion.

## Test plan
Scenarios 1–5 use small timing: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), RD_LAT 2.
1. Reset then run 2 frames in mode 0 with a memory model returning rd_data = addr -> de 8 cycles/line, 4 lines; hsync active for 3 cycles starting 10+3 cycles after line start; grayscale output = addr[7:4] at latency 3.
2. Mode 1, memory returns 12'hA5C at every address -> red A, green 5, blue C while de; 0 during blanking.
3. Mode 2, H_ACTIVE 8 -> one pixel per bar, sequence FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000; rd_en never asserted.
4. Switch mode 0->2 mid-frame -> current frame stays grayscale; the change starts at the next frame_start.
5. Assert reset for 1 cycle mid-line 2 -> outputs return to reset values the next cycle; the first frame_start occurs RD_LAT+1 cycles after release.
6. H_POL = 0, V_POL = 0, RD_LAT = 0 -> syncs idle high and pulse low; latency 1 cycle; frame_start period = 128 cycles.
